param_regfile: RTL and testbench
================================

PARAM_REGFILE -- requirements
Module: param_regfile

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bits per register.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register index width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter NUM_READ, default 2, number of independent read ports.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port ctrl_reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port ctrl_writeEnable  input  1  writeback strobe.
REQ-007 SHALL have port ctrl_writeReg  input  ADDR_WIDTH  writeback index.
REQ-008 SHALL have port data_writeReg  input  DATA_WIDTH  writeback data.
REQ-009 SHALL have port ctrl_readReg  input  NUM_READ*ADDR_WIDTH  packed read indices; port p uses slice p.
REQ-010 SHALL have port data_readReg  output  NUM_READ*DATA_WIDTH  packed read data; port p uses slice p.
REQ-011 SHALL have port busy_readReg  output  NUM_READ  pending-write flag of each read port's register.
REQ-012 SHALL have port ctrl_issueEnable  input  1  marks ctrl_issueReg as awaiting writeback.
REQ-013 SHALL have port ctrl_issueReg  input  ADDR_WIDTH  issued destination index.
REQ-014 SHALL have port ctrl_clear  input  1  one-cycle request to start a clear sweep.
REQ-015 SHALL have port clear_busy  output  1  high while the clear sweep runs.

Function
REQ-016 Reads SHALL be combinational: data_readReg[p] = register[ctrl_readReg[p]]; index 0 always reads 0.
REQ-017 Write SHALL update register[ctrl_writeReg] at the clock edge when ctrl_writeEnable=1, index!=0 and state is IDLE; otherwise no register changes.
REQ-018 Scoreboard: pending[ctrl_issueReg] SHALL set one edge after ctrl_issueEnable=1 (index!=0, state IDLE); pending[ctrl_writeReg] SHALL clear at a valid write.
REQ-019 Issue and write to the same index in the same cycle SHALL leave pending set (the issue wins); different indices update independently.
REQ-020 busy_readReg[p] SHALL equal pending[ctrl_readReg[p]]; pending[0] is always 0.
REQ-021 FSM states IDLE and SWEEP; IDLE->SWEEP on ctrl_clear=1; SWEEP counter starts at 1, zeroes register[cnt] and pending[cnt] each cycle, increments; SWEEP->IDLE after index 2**ADDR_WIDTH-1, i.e. exactly 2**ADDR_WIDTH-1 SWEEP cycles.
REQ-022 clear_busy SHALL be 1 exactly while state is SWEEP; ctrl_clear, writes and issues during SWEEP SHALL be ignored.
REQ-023 Reads during SWEEP SHALL return current contents (already-swept indices read 0).

Reset
REQ-024 ctrl_reset=1 at an edge SHALL zero all registers and pending bits, force IDLE, counter to 1, clear_busy to 0; reset overrides write, issue and clear in that cycle.
REQ-025 Reset during SWEEP SHALL abort the sweep and return to IDLE on the next edge.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN SHALL, when defined, forward data_writeReg to any read port whose index equals ctrl_writeReg during a valid write (REQ-017), and drive that port's busy_readReg to 0 unless an issue to the same index coincides.
REQ-027 Without REGFILE_BYPASS_EN, read ports SHALL return the pre-write value and pre-write pending bit in the write cycle.

Structure
REQ-028 A shared package SHALL hold the FSM state typedef (IDLE, SWEEP) and default-width constants.
REQ-029 The per-port read mux with optional bypass SHALL be one sub-module, regfile_read_port, instantiated NUM_READ times.

Verification
REQ-030 Write 0xDEADBEEF to r5, next cycle read r5 on port 0 and port 1 -> both return 0xDEADBEEF; write 0x1234 to r0 -> r0 reads 0.
REQ-031 Issue r7, next cycle read r7 -> busy_readReg=1; write r7=0x55 -> busy clears next cycle, data 0x55.
REQ-032 Same cycle issue r3 and write r3=0x9 -> r3 reads 0x9 and busy_readReg stays 1.
REQ-033 With REGFILE_BYPASS_EN, write r9=0xA5A5 while reading r9 -> same-cycle read 0xA5A5; without it -> previous value.
REQ-034 Fill r1..r31 nonzero, pulse ctrl_clear -> clear_busy high 31 cycles, all reads 0 afterward, write during sweep discarded.
REQ-035 Assert ctrl_reset at sweep cycle 10 -> clear_busy 0 next cycle, all registers 0, state IDLE.

Source files
------------

// File: rtl/param_regfile_pkg.sv
// Shared types and default sizes for the parameterised register file.
// The optional write-to-read forwarding is enabled with the REGFILE_BYPASS_EN macro.
package param_regfile_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 5;
   localparam int DEF_NUM_READ   = 2;

endpackage

// File: rtl/param_regfile_read_port.sv
// One combinational read port: register select, index-0 zero, optional write forwarding.
// Forwarding of the in-flight write is compiled in only when REGFILE_BYPASS_EN is defined.
module regfile_read_port
   import param_regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] i_regs_flat,
   input  logic [(2**ADDR_WIDTH)-1:0]            i_pending,
   input  logic [ADDR_WIDTH-1:0]                 i_raddr,
   input  logic                                  i_wr_valid,
   input  logic [ADDR_WIDTH-1:0]                 i_waddr,
   input  logic [DATA_WIDTH-1:0]                 i_wdata,
   input  logic                                  i_iss_valid,
   input  logic [ADDR_WIDTH-1:0]                 i_iaddr,
   output logic [DATA_WIDTH-1:0]                 o_rdata,
   output logic                                  o_busy
);

   logic [DATA_WIDTH-1:0] w_stored;
   logic                  w_zero_idx;

   assign w_zero_idx = (i_raddr == '0);
   assign w_stored   = i_regs_flat[int'(i_raddr)*DATA_WIDTH +: DATA_WIDTH];

`ifdef REGFILE_BYPASS_EN
   logic w_fwd;
   logic w_iss_hit;

   // Valid writes never target index 0, so w_fwd already excludes it.
   assign w_fwd     = i_wr_valid && (i_waddr == i_raddr);
   assign w_iss_hit = i_iss_valid && (i_iaddr == i_raddr);

   always_comb begin
      o_rdata = '0;
      o_busy  = 1'b0;
      if (w_fwd) begin
         o_rdata = i_wdata;
         o_busy  = w_iss_hit;
      end else if (!w_zero_idx) begin
         o_rdata = w_stored;
         o_busy  = i_pending[i_raddr];
      end
   end
`else
   logic w_unused;
   assign w_unused = ^{i_wr_valid, i_waddr, i_wdata, i_iss_valid, i_iaddr};

   always_comb begin
      o_rdata = '0;
      o_busy  = 1'b0;
      if (!w_zero_idx) begin
         o_rdata = w_stored;
         o_busy  = i_pending[i_raddr];
      end
   end
`endif

endmodule

// File: rtl/param_regfile.sv
// Register file with pending-write scoreboard and a background clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to matching read ports.
module param_regfile
   import param_regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_READ   = DEF_NUM_READ
) (
   input  logic                           clock,
   input  logic                           ctrl_reset,
   input  logic                           ctrl_writeEnable,
   input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
   input  logic [DATA_WIDTH-1:0]          data_writeReg,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
   output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
   output logic [NUM_READ-1:0]            busy_readReg,
   input  logic                           ctrl_issueEnable,
   input  logic [ADDR_WIDTH-1:0]          ctrl_issueReg,
   input  logic                           ctrl_clear,
   output logic                           clear_busy
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] CNT_FIRST = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] CNT_LAST  = '1;

   logic [DATA_WIDTH-1:0]       r_regs [DEPTH];
   logic [DEPTH-1:0]            r_pending;
   logic [ADDR_WIDTH-1:0]       r_cnt;
   state_t                      r_state;
   state_t                      w_state_nxt;
   logic                        w_wr_valid;
   logic                        w_iss_valid;
   logic [DEPTH*DATA_WIDTH-1:0] w_regs_flat;

   assign w_wr_valid  = ctrl_writeEnable && (ctrl_writeReg != '0) && (r_state == IDLE);
   assign w_iss_valid = ctrl_issueEnable && (ctrl_issueReg != '0) && (r_state == IDLE);
   assign clear_busy  = (r_state == SWEEP);

   always_ff @(posedge clock) begin
      if (ctrl_reset) r_state <= IDLE;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (ctrl_clear) w_state_nxt = SWEEP;
         SWEEP:   if (r_cnt == CNT_LAST) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Sweep index starts at 1 since register 0 is hard-wired to zero.
   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         r_cnt <= CNT_FIRST;
      end else if (r_state == SWEEP) begin
         if (r_cnt == CNT_LAST) r_cnt <= CNT_FIRST;
         else                   r_cnt <= r_cnt + CNT_FIRST;
      end
   end

   // Issue is applied after the write-clear so a same-index issue wins.
   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
         r_pending <= '0;
      end else if (r_state == SWEEP) begin
         r_regs[r_cnt]    <= '0;
         r_pending[r_cnt] <= 1'b0;
      end else begin
         if (w_wr_valid) begin
            r_regs[ctrl_writeReg]    <= data_writeReg;
            r_pending[ctrl_writeReg] <= 1'b0;
         end
         if (w_iss_valid) r_pending[ctrl_issueReg] <= 1'b1;
      end
   end

   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : g_flat
         assign w_regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
      end

      for (g = 0; g < NUM_READ; g++) begin : g_rd
         regfile_read_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
         ) u_read_port (
            .i_regs_flat (w_regs_flat),
            .i_pending   (r_pending),
            .i_raddr     (ctrl_readReg[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .i_wr_valid  (w_wr_valid),
            .i_waddr     (ctrl_writeReg),
            .i_wdata     (data_writeReg),
            .i_iss_valid (w_iss_valid),
            .i_iaddr     (ctrl_issueReg),
            .o_rdata     (data_readReg[g*DATA_WIDTH +: DATA_WIDTH]),
            .o_busy      (busy_readReg[g])
         );
      end
   endgenerate

endmodule

// File: tb/tb_param_regfile.sv
// Directed bench for param_regfile with a cycle-level reference model and literal spot checks.
module tb_param_regfile;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int DEPTH = 2**AW;

   logic              clock = 1'b0;
   logic              ctrl_reset = 1'b1;
   logic              ctrl_writeEnable = 1'b0;
   logic [AW-1:0]     ctrl_writeReg = '0;
   logic [DW-1:0]     data_writeReg = '0;
   logic [AW-1:0]     rd0 = '0;
   logic [AW-1:0]     rd1 = '0;
   logic [NR*AW-1:0]  ctrl_readReg;
   logic [NR*DW-1:0]  data_readReg;
   logic [NR-1:0]     busy_readReg;
   logic              ctrl_issueEnable = 1'b0;
   logic [AW-1:0]     ctrl_issueReg = '0;
   logic              ctrl_clear = 1'b0;
   logic              clear_busy;

   assign ctrl_readReg = {rd1, rd0};

   param_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) dut (
      .clock            (clock),
      .ctrl_reset       (ctrl_reset),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .ctrl_readReg     (ctrl_readReg),
      .data_readReg     (data_readReg),
      .busy_readReg     (busy_readReg),
      .ctrl_issueEnable (ctrl_issueEnable),
      .ctrl_issueReg    (ctrl_issueReg),
      .ctrl_clear       (ctrl_clear),
      .clear_busy       (clear_busy)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: architectural contents, pending bits, sweep progress.
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_pend [DEPTH];
   bit            m_sweep = 0;
   int            m_cnt = 1;
   bit            m_live = 0;

   function automatic bit m_wr_ok();
      return ctrl_writeEnable && ctrl_writeReg != 0 && !m_sweep;
   endfunction

   function automatic bit m_iss_ok();
      return ctrl_issueEnable && ctrl_issueReg != 0 && !m_sweep;
   endfunction

   function automatic logic [DW-1:0] m_data(input logic [AW-1:0] a);
      if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (m_wr_ok() && ctrl_writeReg == a) return data_writeReg;
`endif
      return m_mem[a];
   endfunction

   function automatic logic m_busy(input logic [AW-1:0] a);
      if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (m_wr_ok() && ctrl_writeReg == a) return m_iss_ok() && ctrl_issueReg == a;
`endif
      return m_pend[a];
   endfunction

   always @(posedge clock) begin
      if (ctrl_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_pend[i] = 0;
         end
         m_sweep = 0;
         m_cnt = 1;
         m_live = 1;
      end else if (m_sweep) begin
         m_mem[m_cnt] = '0;
         m_pend[m_cnt] = 0;
         if (m_cnt == DEPTH-1) begin
            m_sweep = 0;
            m_cnt = 1;
         end else begin
            m_cnt++;
         end
      end else begin
         if (m_wr_ok()) begin
            m_mem[ctrl_writeReg] = data_writeReg;
            m_pend[ctrl_writeReg] = 0;
         end
         if (m_iss_ok()) m_pend[ctrl_issueReg] = 1;
         if (ctrl_clear) m_sweep = 1;
      end
   end

   always @(negedge clock) begin
      if (m_live) begin
         check("model_rd0_data", data_readReg[DW-1:0], m_data(rd0));
         check("model_rd1_data", data_readReg[2*DW-1:DW], m_data(rd1));
         check("model_rd0_busy", DW'(busy_readReg[0]), DW'(m_busy(rd0)));
         check("model_rd1_busy", DW'(busy_readReg[1]), DW'(m_busy(rd1)));
         check("model_clear_busy", DW'(clear_busy), DW'(m_sweep));
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg = a;
      data_writeReg = d;
      cyc();
      ctrl_writeEnable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      cyc();
      cyc();
      ctrl_reset = 1'b0;

      rd0 = 5; rd1 = 6;
      @(negedge clock);
      check("reset_clear_busy", DW'(clear_busy), 0);
      check("reset_r5", data_readReg[DW-1:0], 0);
      cyc();

      wr(5, 32'hDEADBEEF);
      rd0 = 5; rd1 = 5;
      @(negedge clock);
      check("r5_port0", data_readReg[DW-1:0], 32'hDEADBEEF);
      check("r5_port1", data_readReg[2*DW-1:DW], 32'hDEADBEEF);
      cyc();
      wr(0, 32'h1234);
      rd0 = 0;
      @(negedge clock);
      check("r0_zero", data_readReg[DW-1:0], 0);
      cyc();

      ctrl_issueEnable = 1'b1; ctrl_issueReg = 7;
      cyc();
      ctrl_issueEnable = 1'b0;
      rd0 = 7;
      @(negedge clock);
      check("r7_busy_set", DW'(busy_readReg[0]), 1);
      cyc();
      wr(7, 32'h55);
      @(negedge clock);
      check("r7_busy_clr", DW'(busy_readReg[0]), 0);
      check("r7_data", data_readReg[DW-1:0], 32'h55);
      cyc();

      ctrl_issueEnable = 1'b1; ctrl_issueReg = 3;
      wr(3, 32'h9);
      ctrl_issueEnable = 1'b0;
      rd0 = 3;
      @(negedge clock);
      check("r3_data", data_readReg[DW-1:0], 32'h9);
      check("r3_busy_kept", DW'(busy_readReg[0]), 1);
      cyc();

      ctrl_issueEnable = 1'b1; ctrl_issueReg = 10;
      wr(11, 32'h7777);
      ctrl_issueEnable = 1'b0;
      rd0 = 10; rd1 = 11;
      @(negedge clock);
      check("r10_busy", DW'(busy_readReg[0]), 1);
      check("r11_busy", DW'(busy_readReg[1]), 0);
      check("r11_data", data_readReg[2*DW-1:DW], 32'h7777);
      cyc();

      wr(9, 32'h1111);
      rd1 = 9;
      ctrl_writeEnable = 1'b1; ctrl_writeReg = 9; data_writeReg = 32'hA5A5;
      @(negedge clock);
`ifdef REGFILE_BYPASS_EN
      check("r9_same_cycle", data_readReg[2*DW-1:DW], 32'hA5A5);
`else
      check("r9_same_cycle", data_readReg[2*DW-1:DW], 32'h1111);
`endif
      cyc();
      ctrl_writeEnable = 1'b0;

      for (int i = 1; i < DEPTH; i++) wr(AW'(i), 32'h100 + i);
      ctrl_issueEnable = 1'b1; ctrl_issueReg = 12;
      cyc();
      ctrl_issueEnable = 1'b0;
      ctrl_clear = 1'b1;
      cyc();
      ctrl_clear = 1'b0;
      n = 0;
      while (clear_busy && n < 100) begin
         ctrl_writeEnable = (n == 5);
         ctrl_writeReg = 2;
         data_writeReg = 32'hBAD;
         ctrl_clear = (n == 10);
         n++;
         cyc();
      end
      ctrl_writeEnable = 1'b0;
      ctrl_clear = 1'b0;
      check("sweep_cycles", n, 31);
      for (int i = 1; i < DEPTH; i++) begin
         rd0 = AW'(i); rd1 = AW'(i);
         @(negedge clock);
         check("post_sweep_data", data_readReg[DW-1:0], 0);
         check("post_sweep_busy", DW'(busy_readReg[0]), 0);
      end
      cyc();

      for (int i = 1; i < DEPTH; i++) wr(AW'(i), 32'hF000 + i);
      ctrl_clear = 1'b1;
      cyc();
      ctrl_clear = 1'b0;
      for (int i = 1; i < 10; i++) cyc();
      ctrl_reset = 1'b1;
      cyc();
      ctrl_reset = 1'b0;
      check("abort_clear_busy", DW'(clear_busy), 0);
      rd0 = 20; rd1 = 31;
      @(negedge clock);
      check("abort_r20", data_readReg[DW-1:0], 0);
      check("abort_r31", data_readReg[2*DW-1:DW], 0);
      cyc();
      wr(4, 32'h77);
      rd0 = 4;
      @(negedge clock);
      check("idle_after_abort", data_readReg[DW-1:0], 32'h77);
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
